// File: rtl/imem_load_ctrl_pkg.sv
// Shared core package for the instruction-memory loader: FSM states and
// default geometry. Optional feature macro: IMEM_LOAD_CHECKSUM_EN.
package imem_load_ctrl_pkg;

    localparam int DEF_MEMORY_WIDTH = 16;
    localparam int DEF_MEMORY_DEPTH = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        WRITE,
        CHECK,
        DONE
    } state_t;

    // States in which the loader pulls bytes from the stream.
    function automatic logic takes_byte(state_t s);
`ifdef IMEM_LOAD_CHECKSUM_EN
        return s inside {LOAD_LO, LOAD_HI, CHECK};
`else
        return s inside {LOAD_LO, LOAD_HI};
`endif
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Byte-stream instruction-memory loader: assembles little-endian halfwords
// and writes them while holding the core. Optional: IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
    parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_load_start,
    input  logic [$clog2(MEMORY_DEPTH):0]   i_load_len,
    input  logic                            i_abort,
    input  logic                            i_byte_valid,
    input  logic [7:0]                      i_byte,
    output logic                            o_byte_ready,
    output logic                            o_mem_we,
    output logic [$clog2(MEMORY_DEPTH)-1:0] o_mem_waddr,
    output logic [MEMORY_WIDTH-1:0]         o_mem_wdata,
    output logic                            o_core_hold,
    output logic                            o_done,
    output logic                            o_err
);

    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(MEMORY_DEPTH);

    state_t state;
    state_t nxt;

    logic [LW-1:0] cnt;
    logic [LW-1:0] len;
    logic [15:0]   half;
    logic [AW-1:0] waddr;
    logic          ready;
    logic          we;
    logic          hold;
    logic          done;
    logic          err;

    logic start;
    logic abort;
    logic xfer;
    logic bad_len;
    logic zero_len;
    logic more;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign start    = i_load_start & (state == IDLE);
    assign abort    = i_abort & (state != IDLE);
    assign bad_len  = i_load_len > DEPTH;
    assign zero_len = i_load_len == '0;
    assign more     = (cnt + LW'(1)) < len;

    // Abort wins over a same-cycle byte or write: neither side sees it.
    assign o_byte_ready = ready & ~abort;
    assign o_mem_we     = we & ~abort;
    assign xfer         = i_byte_valid & o_byte_ready;

    assign o_mem_waddr = waddr;
    assign o_mem_wdata = MEMORY_WIDTH'(half);
    assign o_core_hold = hold;
    assign o_done      = done;
    assign o_err       = err;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (zero_len || bad_len) nxt = DONE;
                    else                     nxt = LOAD_LO;
                end
            end
            LOAD_LO: if (xfer) nxt = LOAD_HI;
            LOAD_HI: if (xfer) nxt = WRITE;
            WRITE:   nxt = more ? LOAD_LO : CHECK;
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK:   if (xfer) nxt = DONE;
`else
            CHECK:   nxt = DONE;
`endif
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = DONE;
    end

    // Outputs are registered from the next state so they track the state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            half  <= '0;
            waddr <= '0;
            ready <= 1'b0;
            we    <= 1'b0;
            hold  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum   <= '0;
`endif
        end else begin
            state <= nxt;
            ready <= takes_byte(nxt);
            we    <= nxt == WRITE;
            hold  <= nxt != IDLE;
            done  <= nxt == DONE;
            if (nxt == WRITE) waddr <= cnt[AW-1:0];
            if (start) begin
                cnt <= '0;
                len <= i_load_len;
                err <= bad_len;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum <= '0;
`endif
            end
            if (xfer && state == LOAD_LO) begin
                half[7:0] <= i_byte;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum <= sum + i_byte;
`endif
            end
            if (xfer && state == LOAD_HI) begin
                half[15:8] <= i_byte;
`ifdef IMEM_LOAD_CHECKSUM_EN
                sum <= sum + i_byte;
`endif
            end
            if (state == WRITE && !abort) cnt <= cnt + LW'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (xfer && state == CHECK && i_byte != sum) err <= 1'b1;
`endif
            if (abort) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed and randomized loads
// compared against a halfword-level model of the byte stream.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_load_start;
    logic [10:0] i_load_len;
    logic        i_abort;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [9:0]  o_mem_waddr;
    logic [15:0] o_mem_wdata;
    logic        o_core_hold;
    logic        o_done;
    logic        o_err;

    imem_load_ctrl #(.MEMORY_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_load_start(i_load_start),
        .i_load_len(i_load_len),
        .i_abort(i_abort),
        .i_byte_valid(i_byte_valid),
        .i_byte(i_byte),
        .o_byte_ready(o_byte_ready),
        .o_mem_we(o_mem_we),
        .o_mem_waddr(o_mem_waddr),
        .o_mem_wdata(o_mem_wdata),
        .o_core_hold(o_core_hold),
        .o_done(o_done),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx[$];
    int          wa[$];
    logic [15:0] wd[$];
    int          done_cnt;
    int          done_cyc;
    int          hold_bad;
    int          rdy_abort_bad;
    int          consumed;
    logic        hold_after;
    logic        err_after;

    // ---------------- reference model (stream level) ----------------
    function automatic int model_nwr(int len, int abort_at);
        if (len == 0 || len > 1024) return 0;
        if (abort_at < 0) return len;
        // An abort landing on the write cycle of a halfword loses it.
        if (abort_at > 0 && abort_at % 2 == 0) return abort_at / 2 - 1;
        return abort_at / 2;
    endfunction

    function automatic logic [15:0] model_half(int k);
        return {tx[2*k+1], tx[2*k]};
    endfunction

    function automatic logic model_err(int len, int abort_at);
        logic [7:0] s;
        if (len > 1024) return 1'b1;
        if (len == 0) return 1'b0;
        if (abort_at >= 0) return 1'b1;
        if (!CK_EN) return 1'b0;
        s = 8'h00;
        for (int i = 0; i < 2 * len; i++) s = s + tx[i];
        return s != tx[2*len];
    endfunction

    function automatic int model_consumed(int len, int abort_at);
        if (len == 0 || len > 1024) return 0;
        if (abort_at >= 0) return abort_at;
        return 2 * len + (CK_EN ? 1 : 0);
    endfunction

    function automatic int bad_writes(int n);
        int b = 0;
        for (int k = 0; k < n && k < wa.size(); k++)
            if (wa[k] != k || wd[k] !== model_half(k)) b++;
        return b;
    endfunction

    // ---------------- stimulus / observation ----------------
    task automatic run_load(input int len, input int vmode,
                            input int abort_at, input bit noise);
        int ptr;
        bit aborted;
        bit v;
        wa.delete();
        wd.delete();
        done_cnt = 0;
        done_cyc = -1;
        hold_bad = 0;
        rdy_abort_bad = 0;
        ptr = 0;
        aborted = 0;
        i_load_len = 11'(len);
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_load_start = 1'b0;
        for (int c = 0; c < 8 * len + 40; c++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            i_byte_valid = v;
            i_byte = (ptr < tx.size()) ? tx[ptr] : 8'($urandom);
            i_abort = !aborted && abort_at >= 0 && ptr == abort_at;
            if (i_abort) aborted = 1'b1;
            i_load_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) i_load_len = 11'($urandom);
            #1;
            if (i_abort && o_byte_ready) rdy_abort_bad++;
            if (i_byte_valid && o_byte_ready) ptr++;
            if (o_mem_we) begin
                wa.push_back(int'(o_mem_waddr));
                wd.push_back(o_mem_wdata);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
                break;
            end
            if (o_core_hold !== 1'b1) hold_bad++;
            @(posedge clk); #1;
        end
        consumed = ptr;
        i_byte_valid = 1'b0;
        i_abort = 1'b0;
        i_load_start = 1'b0;
        @(posedge clk); #1;
        hold_after = o_core_hold;
        err_after = o_err;
        if (o_done) done_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        i_load_start = 1'b0;
        i_load_len = '0;
        i_abort = 1'b0;
        i_byte_valid = 1'b0;
        i_byte = '0;
        #3;
        checks++;
        if ({o_core_hold, o_byte_ready, o_mem_we, o_done, o_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {o_core_hold, o_byte_ready, o_mem_we, o_done, o_err});
        end
        checks++;
        if (o_mem_waddr !== 10'd0 || o_mem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_bus got addr=%0h data=%0h want 0/0",
                     o_mem_waddr, o_mem_wdata);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        tx = '{8'h13, 8'h00, 8'h93, 8'h00};
        if (CK_EN) tx.push_back(8'hA6);
        run_load(2, 0, -1, 1'b0);
        checks++;
        if (wa.size() != 2 || wa[0] != 0 || wd[0] !== 16'h0013 ||
            wa[1] != 1 || wd[1] !== 16'h0093) begin
            errors++;
            $display("FAIL basic_writes got n=%0d want idx0=0013 idx1=0093",
                     wa.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 7) begin
            errors++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d want 1/7",
                     done_cnt, done_cyc);
        end
        checks++;
        if (hold_after !== 1'b0 || hold_bad != 0) begin
            errors++;
            $display("FAIL basic_hold got after=%b bad=%0d want 0/0",
                     hold_after, hold_bad);
        end
        checks++;
        if (err_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got=%b want=0", err_after);
        end
    endtask

    task automatic test_len_zero();
        tx = '{8'h55, 8'h66};
        run_load(0, 0, -1, 1'b0);
        checks++;
        if (wa.size() != 0 || done_cnt != 1 || done_cyc != 0) begin
            errors++;
            $display("FAIL len0 got wr=%0d done=%0d cyc=%0d want 0/1/0",
                     wa.size(), done_cnt, done_cyc);
        end
        checks++;
        if (err_after !== 1'b0 || consumed != 0) begin
            errors++;
            $display("FAIL len0_err got err=%b bytes=%0d want 0/0",
                     err_after, consumed);
        end
    endtask

    task automatic test_overflow();
        tx = '{8'h01, 8'h02};
        run_load(1025, 0, -1, 1'b0);
        checks++;
        if (wa.size() != 0 || done_cnt != 1 || done_cyc != 0) begin
            errors++;
            $display("FAIL ovf got wr=%0d done=%0d cyc=%0d want 0/1/0",
                     wa.size(), done_cnt, done_cyc);
        end
        checks++;
        if (err_after !== 1'b1 || consumed != 0) begin
            errors++;
            $display("FAIL ovf_err got err=%b bytes=%0d want 1/0",
                     err_after, consumed);
        end
    endtask

    task automatic test_toggle();
        tx.delete();
        for (int i = 0; i < 6; i++) tx.push_back(8'($urandom));
        if (CK_EN) tx.push_back(8'(tx[0] + tx[1] + tx[2] + tx[3] + tx[4] + tx[5]));
        run_load(3, 1, -1, 1'b0);
        checks++;
        if (wa.size() != 3 || bad_writes(3) != 0) begin
            errors++;
            $display("FAIL toggle_writes got n=%0d bad=%0d want 3/0",
                     wa.size(), bad_writes(3));
        end
        checks++;
        if (done_cnt != 1 || err_after !== 1'b0) begin
            errors++;
            $display("FAIL toggle_done got done=%0d err=%b want 1/0",
                     done_cnt, err_after);
        end
    endtask

    task automatic test_abort();
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        run_load(4, 0, 3, 1'b0);
        checks++;
        if (wa.size() != 1 || bad_writes(1) != 0) begin
            errors++;
            $display("FAIL abort_writes got n=%0d want 1 (idx0=%h)",
                     wa.size(), model_half(0));
        end
        checks++;
        if (err_after !== 1'b1 || done_cnt != 1 || consumed != 3 ||
            rdy_abort_bad != 0) begin
            errors++;
            $display("FAIL abort_state got err=%b done=%0d bytes=%0d rdy=%0d want 1/1/3/0",
                     err_after, done_cnt, consumed, rdy_abort_bad);
        end
        tx = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CK_EN) tx.push_back(8'(8'hEF + 8'hBE + 8'hAD + 8'hDE));
        run_load(2, 2, -1, 1'b0);
        checks++;
        if (err_after !== 1'b0 || wa.size() != 2 || wd[0] !== 16'hBEEF ||
            wd[1] !== 16'hDEAD) begin
            errors++;
            $display("FAIL restart got err=%b n=%0d want 0/2 BEEF DEAD",
                     err_after, wa.size());
        end
    endtask

    task automatic test_full_depth();
        logic [7:0] s;
        tx.delete();
        s = 8'h00;
        for (int i = 0; i < 2048; i++) begin
            tx.push_back(8'($urandom));
            s = s + tx[i];
        end
        if (CK_EN) tx.push_back(s);
        run_load(1024, 0, -1, 1'b0);
        checks++;
        if (wa.size() != 1024 || bad_writes(1024) != 0 || wa[1023] != 1023) begin
            errors++;
            $display("FAIL full_depth got n=%0d bad=%0d want 1024/0",
                     wa.size(), bad_writes(1024));
        end
        checks++;
        if (err_after !== 1'b0 || done_cyc != 3 * 1024 + 1) begin
            errors++;
            $display("FAIL full_depth_end got err=%b cyc=%0d want 0/%0d",
                     err_after, done_cyc, 3 * 1024 + 1);
        end
    endtask

    task automatic test_random();
        int len;
        int ab;
        int n;
        logic [7:0] s;
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * len - 1) : -1;
            tx.delete();
            s = 8'h00;
            for (int i = 0; i < 2 * len; i++) begin
                tx.push_back(8'($urandom));
                s = s + tx[i];
            end
            if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
            if (CK_EN) tx.push_back(s);
            run_load(len, 2, ab, 1'b1);
            n = model_nwr(len, ab);
            checks++;
            if (wa.size() != n || bad_writes(n) != 0) begin
                errors++;
                $display("FAIL rand%0d_writes got n=%0d bad=%0d want %0d/0",
                         it, wa.size(), bad_writes(n), n);
            end
            checks++;
            if (err_after !== model_err(len, ab) || done_cnt != 1) begin
                errors++;
                $display("FAIL rand%0d_end got err=%b done=%0d want %b/1",
                         it, err_after, done_cnt, model_err(len, ab));
            end
            checks++;
            if (consumed != model_consumed(len, ab) || hold_bad != 0 ||
                hold_after !== 1'b0 || rdy_abort_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_flow got bytes=%0d hold=%0d/%b rdy=%0d want %0d 0/0 0",
                         it, consumed, hold_bad, hold_after, rdy_abort_bad,
                         model_consumed(len, ab));
            end
        end
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_load(2, 0, -1, 1'b0);
        checks++;
        if (err_after !== 1'b0 || wa.size() != 2) begin
            errors++;
            $display("FAIL ck_good got err=%b n=%0d want 0/2", err_after, wa.size());
        end
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        run_load(2, 0, -1, 1'b0);
        checks++;
        if (err_after !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL ck_bad got err=%b done=%0d want 1/1", err_after, done_cnt);
        end
    endtask
`endif

    task automatic test_reset_midload();
        int wr;
        i_load_len = 11'd4;
        i_load_start = 1'b1;
        @(posedge clk); #1;
        i_load_start = 1'b0;
        i_byte_valid = 1'b1;
        i_byte = 8'h5A;
        repeat (4) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({o_core_hold, o_byte_ready, o_mem_we, o_done, o_err} !== 5'b0 ||
            o_mem_waddr !== 10'd0 || o_mem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got ctl=%b addr=%0h data=%0h want 0",
                     {o_core_hold, o_byte_ready, o_mem_we, o_done, o_err},
                     o_mem_waddr, o_mem_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        wr = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (o_mem_we || o_core_hold) wr++;
        end
        i_byte_valid = 1'b0;
        checks++;
        if (wr != 0) begin
            errors++;
            $display("FAIL post_reset_idle got active=%0d want 0", wr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_overflow();
        test_toggle();
        test_abort();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        test_full_depth();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
